// File: rtl/regfile_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_arbiter_if
//   Single-register access channel between one requester and the regfile
//   arbiter. One instance per requester (A = pipeline, B = debug/loader).
//
//   req     requester -> arbiter  access request, held with we/addr/wdata
//                                 stable until gnt
//   we      requester -> arbiter  1 = write, 0 = read
//   addr    requester -> arbiter  register address (ADDR_W bits)
//   wdata   requester -> arbiter  write data (DATA_W bits)
//   gnt     arbiter -> requester  request accepted at the coming clock edge
//   rvalid  arbiter -> requester  read data valid (one cycle after acceptance)
//   rdata   arbiter -> requester  read data, zero while rvalid=0
//
//   master : requester side, slave : arbiter side
// ---------------------------------------------------------------------------
interface regfile_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
//   Shares one 64x32 register file (registered read port) between two
//   requesters. One access is granted per cycle; the granted access drives
//   the regfile ports combinationally so the regfile samples it on the
//   accepting edge, and read data is handed back one cycle later.
//
//   Parameters
//     ADDR_W    register address width
//     DATA_W    data width
//     RR_MODE   0: A has priority, B forced after MAX_WAIT denied cycles
//               1: round-robin between A and B
//     MAX_WAIT  fixed mode: consecutive denied B cycles before B is forced
//
//   Ports
//     clk       clock, all state on the rising edge
//     rst_n     synchronous reset, active low
//     a, b      requester channels (regfile_arbiter_if.slave)
//     rf_rd     regfile write address
//     rf_rs     regfile read address (sout port)
//     rf_rt     regfile read address (tout port), equal to rf_rs
//     rf_din    regfile write data
//     rf_wrt    regfile write enable
//     rf_sout   regfile registered read data
// ---------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_arbiter_if.slave  a,
  regfile_arbiter_if.slave  b,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [ADDR_W-1:0] rf_rs,
  output logic [ADDR_W-1:0] rf_rt,
  output logic [DATA_W-1:0] rf_din,
  output logic              rf_wrt,
  input  logic [DATA_W-1:0] rf_sout
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } gnt_state_t;

  gnt_state_t        state_reg;
  gnt_state_t        state_next;
  logic              rd_pend_reg;
  logic              rd_pend_next;
  logic              prefer_b;      // who wins when both request

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              a_rvalid;
  logic              b_rvalid;

  // -------------------------------------------------------------------------
  // Contention policy. Only the selected policy's state exists.
  // -------------------------------------------------------------------------
  generate
    if (RR_MODE != 0) begin : g_rr
      // 1 = B was granted last. Resets to B so A wins the first tie.
      logic last_b_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          last_b_reg <= 1'b1;
        end else if (state_next == GNT_A) begin
          last_b_reg <= 1'b0;
        end else if (state_next == GNT_B) begin
          last_b_reg <= 1'b1;
        end
      end

      assign prefer_b = !last_b_reg;
    end else begin : g_fixed
      // Consecutive cycles B has been requesting without a grant.
      logic [WAIT_W-1:0] wait_b_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wait_b_reg <= '0;
        end else if (!b.req || state_next == GNT_B) begin
          wait_b_reg <= '0;
        end else if (wait_b_reg != WAIT_W'(MAX_WAIT)) begin
          wait_b_reg <= wait_b_reg + 1'b1;
        end
      end

      assign prefer_b = (wait_b_reg == WAIT_W'(MAX_WAIT));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Arbitration state register: remembers last cycle's grant and whether it
  // was a read, which is exactly what the response path needs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rd_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_pend_reg <= rd_pend_next;
    end
  end

  // Grant decision and selected-request mux. Nothing is granted while reset
  // is asserted, so no write can reach the regfile during reset.
  always_comb begin
    state_next = IDLE;
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;

    if (rst_n) begin
      if (a.req && b.req) begin
        state_next = prefer_b ? GNT_B : GNT_A;
      end else if (a.req) begin
        state_next = GNT_A;
      end else if (b.req) begin
        state_next = GNT_B;
      end
    end

    case (state_next)
      GNT_A: begin
        sel_we    = a.we;
        sel_addr  = a.addr;
        sel_wdata = a.wdata;
      end
      GNT_B: begin
        sel_we    = b.we;
        sel_addr  = b.addr;
        sel_wdata = b.wdata;
      end
      default: begin
      end
    endcase

    rd_pend_next = (state_next != IDLE) && !sel_we;
  end

  assign a.gnt = (state_next == GNT_A);
  assign b.gnt = (state_next == GNT_B);

  // Regfile drive: the sel_* defaults are zero when idle, so every rf_*
  // output is zero without a grant.
  assign rf_wrt = sel_we;
  assign rf_rd  = sel_we ? sel_addr : '0;
  assign rf_din = sel_we ? sel_wdata : '0;
  assign rf_rs  = sel_we ? '0 : sel_addr;
  assign rf_rt  = rf_rs;

  // Responses. Gating with rst_n drops a read accepted on the edge just
  // before reset asserts: its response cycle coincides with reset.
  assign a_rvalid = rst_n && rd_pend_reg && (state_reg == GNT_A);
  assign b_rvalid = rst_n && rd_pend_reg && (state_reg == GNT_B);

  assign a.rvalid = a_rvalid;
  assign b.rvalid = b_rvalid;
  assign a.rdata  = a_rvalid ? rf_sout : '0;
  assign b.rdata  = b_rvalid ? rf_sout : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_arbiter
//   Two arbiters side by side: index 0 in fixed-priority mode (MAX_WAIT=4),
//   index 1 in round-robin mode, each with its own regfile model. Requester
//   index 0 is A, index 1 is B. The stimulus process predicts grants and
//   regfile drive from the arbitration rules and pushes expected read
//   responses into per-stream queues; a monitor on the falling edge pops and
//   compares whenever a response appears.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int MAXW = 4;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // live inputs (driven just after the edge) and staged next-cycle inputs
  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          n_req   [2][2];
  logic          n_we    [2][2];
  logic [AW-1:0] n_addr  [2][2];
  logic [DW-1:0] n_wdata [2][2];

  logic          gnt    [2][2];
  logic          rvalid [2][2];
  logic [DW-1:0] rdata  [2][2];
  logic [AW-1:0] rf_rd [2];
  logic [AW-1:0] rf_rs [2];
  logic [AW-1:0] rf_rt [2];
  logic [DW-1:0] rf_din [2];
  logic          rf_wrt [2];
  logic [DW-1:0] rf_sout [2];

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    regfile_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
    regfile_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

    assign ia.req = req[gi][0];  assign ia.we = we[gi][0];
    assign ia.addr = addr[gi][0]; assign ia.wdata = wdata[gi][0];
    assign ib.req = req[gi][1];  assign ib.we = we[gi][1];
    assign ib.addr = addr[gi][1]; assign ib.wdata = wdata[gi][1];
    assign gnt[gi][0] = ia.gnt; assign rvalid[gi][0] = ia.rvalid; assign rdata[gi][0] = ia.rdata;
    assign gnt[gi][1] = ib.gnt; assign rvalid[gi][1] = ib.rvalid; assign rdata[gi][1] = ib.rdata;

    regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(gi), .MAX_WAIT(MAXW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (ia),
      .b       (ib),
      .rf_rd   (rf_rd[gi]),
      .rf_rs   (rf_rs[gi]),
      .rf_rt   (rf_rt[gi]),
      .rf_din  (rf_din[gi]),
      .rf_wrt  (rf_wrt[gi]),
      .rf_sout (rf_sout[gi])
    );

    // regfile: write on the edge, registered read
    logic [DW-1:0] mem [64] = '{default: '0};
    logic [DW-1:0] sout = '0;
    always @(posedge clk) begin
      if (rf_wrt[gi]) mem[rf_rd[gi]] <= rf_din[gi];
      sout <= mem[rf_rs[gi]];
    end
    assign rf_sout[gi] = sout;
  end

  // scoreboard and model state
  exp_t          exp_q [4][$];
  logic [DW-1:0] ref_mem [2][64];
  int            bwait [2];
  int            last  [2];     // 1 = A, 2 = B
  bit            g     [2][2];  // predicted grant in the latest cycle
  bit            rec = 1'b0;
  string         pat [2];
  int            checks = 0;
  int            errors = 0;
  bit            mon_on = 1'b0;

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_at(input int d, input int a);
    return (d == 0) ? g_dut[0].mem[a] : g_dut[1].mem[a];
  endfunction

  task automatic set_req(input int d, input int r, input logic rq, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] v);
    n_req[d][r] = rq; n_we[d][r] = w; n_addr[d][r] = a; n_wdata[d][r] = v;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) set_req(d, r, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic bit busy(input int d, input int r);
    return n_req[d][r] && !g[d][r];
  endfunction

  // One clock cycle: apply staged inputs, predict and check the grant and
  // regfile drive, update the reference state.
  task automatic step(input logic rst_v);
    @(posedge clk);
    #1;
    rst_n = rst_v;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++) begin
        req[d][r] = n_req[d][r]; we[d][r] = n_we[d][r];
        addr[d][r] = n_addr[d][r]; wdata[d][r] = n_wdata[d][r];
      end
    // a response due in a reset cycle is cancelled
    if (!rst_v)
      for (int s = 0; s < 4; s++)
        while (exp_q[s].size() > 0 && exp_q[s][$].cyc == 32'(cyc)) void'(exp_q[s].pop_back());
    #2;
    for (int d = 0; d < 2; d++) begin
      int eg;
      eg = 0;
      if (rst_v) begin
        if (req[d][0] && req[d][1]) begin
          if (d == 0) eg = (bwait[d] == MAXW) ? 2 : 1;
          else        eg = (last[d] == 1) ? 2 : 1;
        end else if (req[d][0]) eg = 1;
        else if (req[d][1]) eg = 2;
      end
      check("a_gnt", d, 64'(gnt[d][0]), 64'(eg == 1));
      check("b_gnt", d, 64'(gnt[d][1]), 64'(eg == 2));
      if (eg != 0) begin
        int r;
        r = eg - 1;
        check("rf_wrt", d, 64'(rf_wrt[d]), 64'(we[d][r]));
        if (we[d][r]) begin
          check("rf_rd", d, 64'(rf_rd[d]), 64'(addr[d][r]));
          check("rf_din", d, 64'(rf_din[d]), 64'(wdata[d][r]));
          ref_mem[d][addr[d][r]] = wdata[d][r];
        end else begin
          check("rf_rs_rt", d, 64'({rf_rs[d], rf_rt[d]}), 64'({addr[d][r], addr[d][r]}));
          exp_q[d*2+r].push_back('{cyc: 32'(cyc + 1), data: ref_mem[d][addr[d][r]]});
        end
      end else begin
        check("rf_wrt_idle", d, 64'(rf_wrt[d]), 64'd0);
        check("rf_bus_idle", d, 64'({rf_rd[d], rf_rs[d], rf_rt[d], rf_din[d]}), 64'd0);
      end
      if (rec) pat[d] = {pat[d], gnt[d][0] ? "A" : (gnt[d][1] ? "B" : "-")};
      g[d][0] = (eg == 1);
      g[d][1] = (eg == 2);
      if (!rst_v) begin
        bwait[d] = 0;
        last[d]  = 2;
      end else begin
        if (req[d][1] && eg != 2) bwait[d] = (bwait[d] < MAXW) ? bwait[d] + 1 : MAXW;
        else bwait[d] = 0;
        if (eg != 0) last[d] = eg;
      end
    end
  endtask

  // response monitor
  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 2; r++) begin
          int s;
          string nm;
          s  = d * 2 + r;
          nm = (r == 0) ? "a_resp" : "b_resp";
          checks++;
          if (rvalid[d][r]) begin
            if (exp_q[s].size() == 0) begin
              errors++;
              $display("FAIL %s dut%0d cyc=%0d unexpected rvalid rdata=%h", nm, d, cyc, rdata[d][r]);
            end else begin
              exp_t e;
              e = exp_q[s].pop_front();
              if (e.cyc != 32'(cyc) || rdata[d][r] !== e.data) begin
                errors++;
                $display("FAIL %s dut%0d cyc=%0d got rdata=%h want rdata=%h at cyc=%0d",
                         nm, d, cyc, rdata[d][r], e.data, e.cyc);
              end
            end
          end else if (rdata[d][r] !== '0) begin
            errors++;
            $display("FAIL %s_idle dut%0d cyc=%0d got rdata=%h want 0", nm, d, cyc, rdata[d][r]);
          end else if (exp_q[s].size() > 0 && exp_q[s][0].cyc <= 32'(cyc)) begin
            exp_t e;
            e = exp_q[s].pop_front();
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got no rvalid want rdata=%h", nm, d, cyc, e.data);
          end
        end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 64; a++) ref_mem[d][a] = '0;
      bwait[d] = 0; last[d] = 2;
      g[d][0] = 0; g[d][1] = 0;
    end
    idle_all();
    mon_on = 1'b1;

    // reset, then A writes r5 and reads it back
    step(1'b0); step(1'b0); step(1'b1);
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
    step(1'b1);
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 1'b0, 6'd5, '0);
    step(1'b1);
    idle_all();
    step(1'b1); step(1'b1);

    // continuous contention from reset: A writes, B reads
    step(1'b0); step(1'b0);
    pat[0] = ""; pat[1] = "";
    rec = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (!busy(d, 0)) set_req(d, 0, 1'b1, 1'b1, 6'($urandom_range(0, 63)), $urandom);
        if (!busy(d, 1)) set_req(d, 1, 1'b1, 1'b0, 6'($urandom_range(0, 63)), '0);
      end
      step(1'b1);
    end
    rec = 1'b0;
    checks++;
    if (pat[0] != "AAAABAAAAB") begin
      errors++;
      $display("FAIL fixed_pattern dut0 got=%s want=AAAABAAAAB", pat[0]);
    end
    checks++;
    if (pat[1] != "ABABABABAB") begin
      errors++;
      $display("FAIL rr_pattern dut1 got=%s want=ABABABABAB", pat[1]);
    end
    idle_all();
    step(1'b1); step(1'b1);

    // B writes r2=7, A reads r2 on the next cycle
    for (int d = 0; d < 2; d++) set_req(d, 1, 1'b1, 1'b1, 6'd2, 32'd7);
    step(1'b1);
    idle_all();
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 1'b0, 6'd2, '0);
    step(1'b1);
    idle_all();
    step(1'b1); step(1'b1);

    // read accepted right before reset; write attempted during reset
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 1'b0, 6'd5, '0);
    step(1'b1);
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 1'b1, 6'd9, 32'h12345678);
    step(1'b0);
    idle_all();
    step(1'b1);
    for (int d = 0; d < 2; d++) check("mem_r9_after_reset", d, 64'(mem_at(d, 9)), 64'(ref_mem[d][9]));

    // idle stretch
    for (int i = 0; i < 10; i++) step(1'b1);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 2; r++)
          if (!busy(d, r)) begin
            if ($urandom_range(0, 99) < 55)
              set_req(d, r, 1'b1, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 7)), $urandom);
            else
              set_req(d, r, 1'b0, 1'b0, '0, '0);
          end
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
    end

    idle_all();
    for (int i = 0; i < 4; i++) step(1'b1);
    @(negedge clk);
    #1;
    for (int s = 0; s < 4; s++) check("queue_drained", s / 2, 64'(exp_q[s].size()), 64'd0);
    for (int d = 0; d < 2; d++) begin
      int bad;
      bad = 0;
      for (int a = 0; a < 64; a++) if (mem_at(d, a) !== ref_mem[d][a]) bad++;
      check("regfile_image_bad_words", d, 64'(bad), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
